uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, clock cycles per serial bit; SHALL be >= 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 Rx  input  1  asynchronous serial line; idle high; 8N1 frame, LSB first.
REQ-005 rx_data  output  8  last correctly framed byte; holds until the next good frame.
REQ-006 rx_valid  output  1  one-cycle pulse when rx_data is updated.
REQ-007 frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-008 rx_busy  output  1  high in every state except IDLE.

Function
REQ-009 Rx SHALL pass through a 2-flop synchronizer; rxs denotes the second flop, reset value 1; 2-cycle latency.
REQ-010 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-011 IDLE: when rxs==0, go to START and clear the cycle counter; otherwise stay.
REQ-012 START: count to (CLKS_PER_BIT-1)/2 (integer division), then sample rxs: if 0, go to DATA and clear the counter; if 1 (glitch), go to IDLE with no output pulse.
REQ-013 DATA: sample rxs on every counter value CLKS_PER_BIT-1.
REQ-014 DATA: shift each sample into bit[index] of the shift register, index 0..7.
REQ-015 DATA: go to STOP after index 7.
REQ-016 STOP: sample rxs at counter value CLKS_PER_BIT-1.
REQ-017 STOP, sample 1: load rx_data from the shift register, pulse rx_valid in the next cycle, go to IDLE.
REQ-018 STOP, sample 0: pulse frame_err, leave rx_data unchanged, go to WAIT_IDLE.
REQ-019 WAIT_IDLE: stay until rxs==1, then go to IDLE; a held-low line (break) SHALL NOT start a frame.
REQ-020 Data bit n (0..7) SHALL be sampled exactly (CLKS_PER_BIT-1)/2 + (n+1)*CLKS_PER_BIT cycles after the first START cycle.
REQ-021 The stop bit SHALL be sampled exactly (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT cycles after the first START cycle.
REQ-022 The cycle counter SHALL be $clog2(CLKS_PER_BIT) bits wide, wrap to 0 after CLKS_PER_BIT-1, and never overflow.
REQ-023 The bit index SHALL be 3 bits and clear on entry to DATA.
REQ-024 rx_valid and frame_err SHALL never assert in the same cycle; each is high for exactly one cycle per frame.
REQ-025 Back-to-back frames: a start bit immediately after a good stop bit SHALL be detected, with no gap cycles required beyond stop-bit completion.

Reset
REQ-026 On rst: state IDLE, counter 0, index 0, shift register 0, rx_data 0x00, rx_valid 0, frame_err 0, rx_busy 0, synchronizer flops 1.
REQ-027 rst asserted mid-frame SHALL abort the frame with no rx_valid or frame_err pulse; reception resumes at the next falling edge after rst deasserts.

Structure
REQ-028 Package uart_pkg SHALL hold the FSM state enum and DATA_BITS=8, shared with the transmitter.
REQ-029 The synchronizer SHALL be a sub-module sync_2ff with reset value parameter INIT=1.
REQ-030 The FSM, counter and shift register SHALL remain in uart_rx.

Verification (CLKS_PER_BIT=4, clk period 100)
REQ-031 Loopback from UART_TX, 0xA1 -> rx_data=0xA1, one rx_valid pulse, frame_err stays 0.
REQ-032 Back-to-back 0xA1 then 0xA0 -> two rx_valid pulses, rx_data 0xA1 then 0xA0.
REQ-033 Rx low for 1 cycle only -> FSM returns to IDLE from START, no rx_valid, no frame_err.
REQ-034 Frame 0x55 with stop bit driven 0 -> frame_err pulse, rx_data keeps previous 0xA0, FSM waits in WAIT_IDLE until Rx=1.
REQ-035 rst pulsed during data bit 3 of 0xFF -> no pulses, rx_data=0x00; next frame 0x00 -> rx_data=0x00 with one rx_valid pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and frame geometry.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to INIT.
module sync_2ff #(
    parameter logic INIT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= INIT;
            sync_q <= INIT;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronized line, mid-bit sampling, framing-error detection.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] sreg_q, sreg_d;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 data_load;
    logic                 err_set;
    logic                 rxs;
    logic                 cnt_last;

    sync_2ff #(
        .INIT (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (Rx),
        .q_o (rxs)
    );

    assign cnt_last = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!rxs) state_d = StStart;
            end
            StStart: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (cnt_q == CNT_HALF) state_d = rxs ? StIdle : StData;
            end
            StData: begin
                if (cnt_last && idx_q == IDX_LAST) state_d = StStop;
            end
            StStop: begin
                if (cnt_last) state_d = rxs ? StIdle : StWaitIdle;
            end
            StWaitIdle: begin
                if (rxs) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        sreg_d    = sreg_q;
        data_load = 1'b0;
        err_set   = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
            end
            StStart: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    idx_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StData: begin
                if (cnt_last) begin
                    cnt_d         = '0;
                    sreg_d[idx_q] = rxs;
                    idx_d         = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStop: begin
                if (cnt_last) begin
                    cnt_d     = '0;
                    data_load = rxs;
                    err_set   = ~rxs;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWaitIdle: begin
                cnt_d = '0;
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            sreg_q      <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sreg_q      <= sreg_d;
            rx_valid_q  <= data_load;
            frame_err_q <= err_set;
            if (data_load) rx_data_q <= sreg_q;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 4 clocks per bit: good frames, glitch, framing error, reset abort.
module tb_uart_rx;

    localparam int unsigned CPB = 4;

    logic       clk;
    logic       rst;
    logic       Rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int checks;
    int errors;
    int valid_cnt;
    int err_cnt;
    int both_cnt;
    logic [7:0] got_q[$];

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Rx        (Rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Pulse monitor: every high cycle of rx_valid / frame_err is counted.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                valid_cnt <= valid_cnt + 1;
                got_q.push_back(rx_data);
            end
            if (frame_err) err_cnt <= err_cnt + 1;
            if (rx_valid && frame_err) both_cnt <= both_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        Rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(stop);
    endtask

    task automatic idle_cycles(input int n);
        Rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        valid_cnt = 0;
        err_cnt   = 0;
        both_cnt  = 0;
        rst       = 1'b1;
        Rx        = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_rx_busy", 32'(rx_busy), 32'h0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(4);
        @(negedge clk);
        check("idle_busy", 32'(rx_busy), 32'h0);
        @(posedge clk);
        #1;

        // Single frame with exact stop-sample latency: pulse lands one edge after the stop bit.
        send_byte(8'hA1, 1'b1);
        @(negedge clk);
        check("a1_valid_early", 32'(rx_valid), 32'h0);
        @(negedge clk);
        check("a1_valid_pulse", 32'(rx_valid), 32'h1);
        check("a1_rx_data", 32'(rx_data), 32'hA1);
        @(negedge clk);
        check("a1_valid_one_cycle", 32'(rx_valid), 32'h0);
        idle_cycles(4);
        check("a1_valid_cnt", 32'(valid_cnt), 32'd1);
        check("a1_err_cnt", 32'(err_cnt), 32'd0);
        check("a1_busy_after", 32'(rx_busy), 32'h0);

        // Back-to-back frames with no idle gap between stop and start.
        send_byte(8'hA1, 1'b1);
        send_byte(8'hA0, 1'b1);
        idle_cycles(6);
        check("b2b_valid_cnt", 32'(valid_cnt), 32'd3);
        check("b2b_first", (got_q.size() > 1) ? 32'(got_q[1]) : 32'hDEAD, 32'hA1);
        check("b2b_second", (got_q.size() > 2) ? 32'(got_q[2]) : 32'hDEAD, 32'hA0);
        check("b2b_rx_data", 32'(rx_data), 32'hA0);

        // One-cycle low glitch: START entered, rejected at mid-bit.
        Rx = 1'b0;
        @(posedge clk);
        #1;
        Rx = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_start", 32'(rx_busy), 32'h1);
        repeat (6) @(negedge clk);
        check("glitch_busy_idle", 32'(rx_busy), 32'h0);
        check("glitch_valid_cnt", 32'(valid_cnt), 32'd3);
        check("glitch_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;

        // Framing error, then a held-low break that must not start a frame.
        send_byte(8'h55, 1'b0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("ferr_err_cnt", 32'(err_cnt), 32'd1);
        check("ferr_rx_data_kept", 32'(rx_data), 32'hA0);
        check("ferr_wait_busy", 32'(rx_busy), 32'h1);
        @(posedge clk);
        #1;
        idle_cycles(5);
        @(negedge clk);
        check("ferr_release_busy", 32'(rx_busy), 32'h0);
        check("ferr_valid_cnt", 32'(valid_cnt), 32'd3);
        check("ferr_err_cnt_after", 32'(err_cnt), 32'd1);
        @(posedge clk);
        #1;

        // Reset during data bit 3 of 0xFF aborts the frame silently.
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        Rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(5 * CPB + 4);
        check("abort_valid_cnt", 32'(valid_cnt), 32'd3);
        check("abort_err_cnt", 32'(err_cnt), 32'd1);
        check("abort_rx_data", 32'(rx_data), 32'h00);
        check("abort_busy", 32'(rx_busy), 32'h0);

        send_byte(8'h00, 1'b1);
        idle_cycles(6);
        check("zero_valid_cnt", 32'(valid_cnt), 32'd4);
        check("zero_got", (got_q.size() > 3) ? 32'(got_q[3]) : 32'hDEAD, 32'h00);
        check("zero_rx_data", 32'(rx_data), 32'h00);
        check("zero_err_cnt", 32'(err_cnt), 32'd1);
        check("never_both", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
